// File: rtl/nibble_packer_pkg.sv
// nibble_packer_pkg
//   Shared definitions for the nibble packer slice.
//   - fifo_state_e    : occupancy state of the two-entry output FIFO
//   - NIB_W           : width of one input nibble
//   - NIBBLES_DEFAULT : default number of nibbles per packed word
//   Optional feature macro used by the slice: NIBBLE_PACKER_PARITY_EN
package nibble_packer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    localparam int NIB_W           = 4;
    localparam int NIBBLES_DEFAULT = 4;

endpackage

// File: rtl/nibble_fifo2.sv
// nibble_fifo2
//   Two-entry FIFO that buffers completed words for the consumer.
//   The head entry drives the outputs directly from flops, so nothing on the
//   input side reaches out_data/out_valid combinationally.
//   A push that arrives while both entries are occupied and the consumer is
//   not draining is dropped and raises a sticky overflow flag.
//
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset
//     in_valid  in   push request (one completed word)
//     in_data   in   word to push            [WIDTH-1:0]
//     out_ready in   consumer accepts the head entry this cycle
//     out_data  out  head entry, registered  [WIDTH-1:0]
//     out_valid out  FIFO not empty, registered
//     overflow  out  sticky, set when a push is dropped
module nibble_fifo2
    import nibble_packer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overflow
);

    fifo_state_e      state;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] tail_reg;
    logic             valid_reg;
    logic             overflow_reg;
    logic             pop;

    assign pop       = valid_reg && out_ready;
    assign out_data  = head_reg;
    out_valid_assign: assert property (@(posedge clk) disable iff (rst) valid_reg == (state != EMPTY));
    assign out_valid = valid_reg;
    assign overflow  = overflow_reg;

    // Occupancy FSM plus the two storage slots. The head slot always holds the
    // oldest word; when it drains, the tail slot (if occupied) moves forward.
    // A simultaneous push and pop keeps the occupancy unchanged in every state,
    // including FULL where the pop frees the slot the push needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            head_reg     <= '0;
            tail_reg     <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        head_reg  <= in_data;
                        valid_reg <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_valid && pop) begin
                        head_reg <= in_data;
                    end else if (in_valid) begin
                        tail_reg <= in_data;
                        state    <= FULL;
                    end else if (pop) begin
                        valid_reg <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (in_valid && pop) begin
                        head_reg <= tail_reg;
                        tail_reg <= in_data;
                    end else if (pop) begin
                        head_reg <= tail_reg;
                        state    <= ONE;
                    end else if (in_valid) begin
                        overflow_reg <= 1'b1;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/nibble_packer.sv
// nibble_packer
//   Packs a stream of 4-bit nibbles LSB-first into NIBBLES-nibble words and
//   hands completed words to a two-entry FIFO (nibble_fifo2).
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     en         in   nibble strobe; data_in sampled when high
//     data_in    in   nibble                       [3:0]
//     flush      in   discard the partial word (wins over en)
//     word       out  head-of-FIFO packed word     [WORD_W-1:0]
//     word_valid out  word holds valid data
//     word_ready in   consumer accepts word this cycle
//     overflow   out  sticky, set when a completed word is dropped
//     word_par   out  XOR of all bits of word (only with NIBBLE_PACKER_PARITY_EN)
//
//   Build option: define NIBBLE_PACKER_PARITY_EN to add word_par, stored
//   alongside each FIFO entry.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEFAULT,
    parameter int WORD_W  = NIB_W * NIBBLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NIB_W-1:0]  data_in,
    input  logic              flush,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overflow
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    output logic              word_par
`endif
);

    localparam int               CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    logic [CNT_W-1:0]  nib_cnt;
    logic [WORD_W-1:0] asm_reg;
    logic [WORD_W-1:0] asm_next;
    logic              capture;
    logic              push;

    assign capture = en && !flush;
    assign push    = capture && (nib_cnt == LAST_NIB);

    // The assembly register with the incoming nibble dropped into the slot
    // selected by the counter. On the last nibble this is the completed word
    // handed to the FIFO, so the final nibble is included without a delay.
    always_comb begin
        asm_next = asm_reg;
        for (int k = 0; k < NIBBLES; k++) begin
            if (nib_cnt == CNT_W'(k)) begin
                asm_next[k*NIB_W +: NIB_W] = data_in;
            end
        end
    end

    // Counter and assembly register. Completing a word wraps straight back to
    // slot 0 so back-to-back words need no idle cycle; the register is cleared
    // at that point so a stale word never leaks into the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib_cnt <= '0;
            asm_reg <= '0;
        end else if (flush) begin
            nib_cnt <= '0;
            asm_reg <= '0;
        end else if (en) begin
            if (push) begin
                nib_cnt <= '0;
                asm_reg <= '0;
            end else begin
                nib_cnt <= nib_cnt + CNT_W'(1);
                asm_reg <= asm_next;
            end
        end
    end

`ifdef NIBBLE_PACKER_PARITY_EN
    // Parity rides as an extra top bit of each FIFO entry, so it is stored per
    // entry and comes out of reset as 0 together with the word.
    localparam int FIFO_W = WORD_W + 1;

    logic [FIFO_W-1:0] fifo_in;
    logic [FIFO_W-1:0] fifo_out;

    assign fifo_in  = {^asm_next, asm_next};
    assign word     = fifo_out[WORD_W-1:0];
    assign word_par = fifo_out[WORD_W];
`else
    localparam int FIFO_W = WORD_W;

    logic [FIFO_W-1:0] fifo_in;
    logic [FIFO_W-1:0] fifo_out;

    assign fifo_in = asm_next;
    assign word    = fifo_out;
`endif

    nibble_fifo2 #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_data   (fifo_in),
        .out_ready (word_ready),
        .out_data  (fifo_out),
        .out_valid (word_valid),
        .overflow  (overflow)
    );

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer
//   Directed bench for nibble_packer (default NIBBLES=4, 16-bit words).
//   A queue-based reference model follows the packing/FIFO rules and is
//   compared against the DUT every cycle; directed scenarios add literal
//   expectations for specific words and flags.
//   Honours NIBBLE_PACKER_PARITY_EN when the design is built with it.
module tb_nibble_packer;

    localparam int NIB = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  data_in;
    logic        flush;
    logic [15:0] word;
    logic        word_valid;
    logic        word_ready;
    logic        overflow;
`ifdef NIBBLE_PACKER_PARITY_EN
    logic        word_par;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_cnt;
    logic [31:0] m_asm;
    logic [15:0] m_q[$];
    logic        m_ovf;
    logic        m_pop;
    logic        m_push;
    logic [15:0] m_pw;

    nibble_packer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data_in    (data_in),
        .flush      (flush),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overflow   (overflow)
`ifdef NIBBLE_PACKER_PARITY_EN
        ,
        .word_par   (word_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: nibbles accumulate into a word; a completed word joins
    // a queue limited to two entries, after any pop on the same edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            m_asm = '0;
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            m_pop  = (m_q.size() > 0) && word_ready;
            m_push = 1'b0;
            m_pw   = '0;
            if (flush) begin
                m_cnt = 0;
                m_asm = '0;
            end else if (en) begin
                m_asm[m_cnt*4 +: 4] = data_in;
                m_cnt = m_cnt + 1;
                if (m_cnt == NIB) begin
                    m_push = 1'b1;
                    m_pw   = m_asm[15:0];
                    m_cnt  = 0;
                    m_asm  = '0;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < 2) m_q.push_back(m_pw);
                else m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled after the edge settles
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            checks++;
            if (word_valid !== (m_q.size() > 0)) begin
                errors++;
                $display("[TB] FAIL model_valid: got %b expected %b at %0t", word_valid, (m_q.size() > 0), $time);
            end
            if (m_q.size() > 0) begin
                checks++;
                if (word !== m_q[0]) begin
                    errors++;
                    $display("[TB] FAIL model_word: got %h expected %h at %0t", word, m_q[0], $time);
                end
`ifdef NIBBLE_PACKER_PARITY_EN
                checks++;
                if (word_par !== ^m_q[0]) begin
                    errors++;
                    $display("[TB] FAIL model_par: got %b expected %b at %0t", word_par, ^m_q[0], $time);
                end
`endif
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("[TB] FAIL model_overflow: got %b expected %b at %0t", overflow, m_ovf, $time);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One full cycle: drive on the falling edge, return just after the rising edge
    task automatic applyStimulus(input logic e, input logic [3:0] d, input logic f, input logic r);
        @(negedge clk);
        en         = e;
        data_in    = d;
        flush      = f;
        word_ready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic sendWord(input logic [3:0] n, input logic r);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, n, 1'b0, r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 1'b0, r);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulseReset(input string tag);
        @(negedge clk);
        en    = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;
        #1;
        checkOutput({tag, "_word"},     32'(word),       32'h0);
        checkOutput({tag, "_valid"},    32'(word_valid), 32'h0);
        checkOutput({tag, "_overflow"}, 32'(overflow),   32'h0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        data_in    = 4'h0;
        flush      = 1'b0;
        word_ready = 1'b0;
        #1;
        checkOutput("reset_word",     32'(word),       32'h0);
        checkOutput("reset_valid",    32'(word_valid), 32'h0);
        checkOutput("reset_overflow", 32'(overflow),   32'h0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        // Reset and fill: A,B,C,D with the consumer ready
        $display("[TB] scenario: reset and fill");
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'hB, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b1);
        checkOutput("fill_not_early", 32'(word_valid), 32'h0);
        applyStimulus(1'b1, 4'hD, 1'b0, 1'b1);
        checkOutput("fill_word",     32'(word),       32'h0000_DCBA);
        checkOutput("fill_valid",    32'(word_valid), 32'h1);
        checkOutput("fill_overflow", 32'(overflow),   32'h0);
`ifdef NIBBLE_PACKER_PARITY_EN
        checkOutput("fill_par",      32'(word_par),   32'h0);
`endif
        idle(1, 1'b1);
        checkOutput("fill_one_cycle", 32'(word_valid), 32'h0);

        // Gapped input: three idle cycles between nibbles
        $display("[TB] scenario: gapped input");
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        idle(3, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        idle(3, 1'b0);
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        idle(3, 1'b0);
        applyStimulus(1'b1, 4'h4, 1'b0, 1'b0);
        checkOutput("gap_word",  32'(word),       32'h0000_4321);
        checkOutput("gap_valid", 32'(word_valid), 32'h1);
        idle(2, 1'b0);
        checkOutput("gap_hold", 32'(word), 32'h0000_4321);
        idle(1, 1'b1);
        checkOutput("gap_drained", 32'(word_valid), 32'h0);

        // Backpressure: three words at full rate with the consumer stalled
        $display("[TB] scenario: backpressure");
        sendWord(4'h1, 1'b0);
        sendWord(4'h2, 1'b0);
        checkOutput("bp_full_word",   32'(word),     32'h0000_1111);
        checkOutput("bp_no_overflow", 32'(overflow), 32'h0);
        sendWord(4'h3, 1'b0);
        checkOutput("bp_head_kept", 32'(word),     32'h0000_1111);
        checkOutput("bp_overflow",  32'(overflow), 32'h1);
        idle(1, 1'b1);
        checkOutput("bp_second", 32'(word), 32'h0000_2222);
        idle(1, 1'b1);
        checkOutput("bp_empty",         32'(word_valid), 32'h0);
        checkOutput("bp_overflow_held", 32'(overflow),   32'h1);
        pulseReset("rst1");

        // Full FIFO with push and pop on the same edge
        $display("[TB] scenario: full with push and pop");
        sendWord(4'hA, 1'b0);
        sendWord(4'hB, 1'b0);
        checkOutput("pp_head_a", 32'(word), 32'h0000_AAAA);
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b1);
        checkOutput("pp_head_b", 32'(word), 32'h0000_BBBB);
        idle(1, 1'b1);
        checkOutput("pp_head_c",   32'(word),     32'h0000_CCCC);
        checkOutput("pp_overflow", 32'(overflow), 32'h0);
        idle(1, 1'b1);
        checkOutput("pp_empty", 32'(word_valid), 32'h0);

        // Flush wins over en; the 7 is discarded along with 5,6
        $display("[TB] scenario: flush");
        applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h6, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
        checkOutput("flush_not_early", 32'(word_valid), 32'h0);
        applyStimulus(1'b1, 4'hB, 1'b0, 1'b0);
        checkOutput("flush_word", 32'(word), 32'h0000_BA98);
        idle(1, 1'b1);

        // Mid-word reset with a word already queued
        $display("[TB] scenario: mid-word reset");
        sendWord(4'h5, 1'b0);
        applyStimulus(1'b1, 4'hE, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
        pulseReset("rst2");
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h4, 1'b0, 1'b0);
        checkOutput("rst_word",  32'(word),       32'h0000_4321);
        checkOutput("rst_valid", 32'(word_valid), 32'h1);
        idle(2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 Parameter NIBBLES, default 4: nibbles per output word; legal range 2..8.
REQ-002 Parameter WORD_W, default 4*NIBBLES: output word width; fixed by NIBBLES and not overridden independently.
REQ-003 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  nibble-valid strobe from the upstream stage; data_in is sampled on a clk edge only when en=1.
REQ-006 data_in  input  4  nibble from the upstream stage's data_out.
REQ-007 flush  input  1  discards the partial word in progress.
REQ-008 word  output  WORD_W  head-of-FIFO packed word.
REQ-009 word_valid  output  1  word holds valid data.
REQ-010 word_ready  input  1  consumer accepts word this cycle.
REQ-011 overflow  output  1  sticky flag; set when a completed word is dropped.

Function
REQ-012 The nibble counter nib_cnt runs 0..NIBBLES-1 and increments on each clk edge with en=1 and flush=0.
REQ-013 Nibble k (k = nib_cnt at capture) is written to bits [4k+3:4k] of the assembly register, so the word is packed LSB-first.
REQ-014 On the edge capturing nibble NIBBLES-1, the completed word, including that nibble, is pushed to a 2-entry FIFO, and nib_cnt wraps to 0 on the same edge.
REQ-015 Latency: word_valid is high immediately after the edge that captures the last nibble, provided the FIFO was empty.
REQ-016 word_valid = FIFO not empty; word = oldest entry; a pop occurs on an edge where word_valid=1 and word_ready=1.
REQ-017 word and word_valid are registered FIFO outputs, with no combinational path from any input.
REQ-018 word holds stable while word_valid=1 and word_ready=0.
REQ-019 The FIFO FSM has three states:
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - FULL -> ONE on pop without push.
  - All other combinations hold state.
REQ-020 Push and pop on the same edge: the push is accepted in every state, including FULL (the pop frees the slot), and the state is unchanged.
REQ-021 Push while FULL without a pop: the word is dropped, the FIFO contents are unchanged, and overflow is set to 1.
REQ-022 overflow stays at 1 until rst.
REQ-023 flush=1 sets nib_cnt to 0 and clears the assembly register.
REQ-024 flush has priority over en in the same cycle: that nibble is discarded.
REQ-025 flush does not touch FIFO contents.
REQ-026 en=0 holds nib_cnt and the assembly register unchanged; gaps between nibbles of any length are legal.
REQ-027 The counter wraps modulo NIBBLES with no idle cycle, so back-to-back words are accepted at full rate.

Reset
REQ-028 rst=1 asynchronously sets the following:
  - nib_cnt=0
  - assembly register=0
  - FIFO state EMPTY
  - word_valid=0
  - word=0
  - overflow=0
REQ-029 A partial word in progress when rst asserts is lost, and the first nibble after rst deasserts lands in bits [3:0].
REQ-030 rst deassertion takes effect at the first clk edge after release; no nibble is captured while rst=1.

Configuration
REQ-031 With macro NIBBLE_PACKER_PARITY_EN defined, the block adds the following:
  - output word_par (1 bit), equal to the XOR of all bits of word.
  - word_par is stored per FIFO entry and is 0 out of reset.
REQ-032 Without NIBBLE_PACKER_PARITY_EN, the port word_par and its storage do not exist.

Structure
REQ-033 Package nibble_packer_pkg holds the following:
  - the fifo_state_e enum (EMPTY, ONE, FULL).
  - constant NIB_W=4.
  - the default NIBBLES constant.
REQ-034 The FIFO is a sub-module, nibble_fifo2, parameterised by width, that owns the FSM, the overflow logic and the registered outputs.
REQ-035 nibble_packer contains only the counter, the assembly logic and the instantiation of nibble_fifo2.

Verification
REQ-036 Reset and fill: after rst, en=1 for 4 cycles with data_in A,B,C,D and word_ready=1 -> word=16'hDCBA with word_valid=1 for exactly one cycle, and overflow=0.
REQ-037 Gapped input: nibbles 1,2,3,4 with 3 idle cycles between each -> word=16'h4321.
REQ-038 Backpressure: word_ready=0 while 3 words stream in (1111, 2222, 3333) -> FIFO FULL with word=16'h1111, the third word is dropped and overflow=1; then word_ready=1 -> 16'h1111, then 16'h2222, after which word_valid=0.
REQ-039 Full with simultaneous push and pop: FIFO FULL (AAAA, BBBB), word_ready=1 on the edge completing CCCC -> output order AAAA, BBBB, CCCC and overflow stays 0.
REQ-040 Flush: nibbles 5,6 then flush=1 together with en=1 and data_in=7, then nibbles 8,9,A,B -> word=16'hBA98.
REQ-041 Mid-word reset: 2 nibbles in, then rst pulsed between edges -> outputs are 0 immediately; the next 4 nibbles 1,2,3,4 -> word=16'h4321.
